pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed EX/MEM-style pipeline register for the RISC-V core.
- A single generic stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble insertion.
- Sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It lets a downstream stall propagate upstream one cycle late, with no combinational ready path.

Parameters:
- DATA_W, 32, width of the datapath payload (PC, ALU result, operands, Rd, etc. concatenated). Held, not cleared, on bubble.
- CTRL_W, 16, width of the control payload (regWrite, memRead, memWrite, jumpSel, etc.). Forced to 0 on bubble.
- CNT_W, 16, width of the stall counter (optional feature only).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-low
- flush  input  1  synchronous kill of all held entries and of the current input
- in_valid  input  1  upstream has a beat
- in_ready  output  1  stage can accept a beat; driven from state register only
- in_data  input  DATA_W  upstream data payload
- in_ctrl  input  CTRL_W  upstream control payload
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts the beat
- out_data  output  DATA_W  data of head entry
- out_ctrl  output  CTRL_W  control of head entry; 0 when out_valid=0
- occupancy  output  2  number of held entries (0, 1 or 2)
- stall_cnt  output  CNT_W  present only with PIPE_STAGE_STATS_EN

Behaviour:
- Reset (rst=0, asynchronous, active-low; clock clk):
  - state EMPTY
  - out_valid=0, out_data=0, out_ctrl=0, skid entry=0
  - occupancy=0, in_ready=1
- Handshake:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
  - Payload must be held stable by the sender while valid is high and ready is low. The stage obeys the same rule on its output.
- Storage and signals:
  - Two entries: head (drives outputs) and skid.
  - in_ready = (state != FULL), registered. No combinational path from out_ready or in_valid to in_ready.
- State transitions, evaluated per clk when flush=0:
  - EMPTY: in_fire -> head<=in, ONE. Otherwise stay EMPTY.
  - ONE, in_fire & out_fire -> head<=in, stay ONE (full throughput).
  - ONE, in_fire & !out_fire -> skid<=in, FULL.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> hold.
  - FULL (in_ready=0): out_fire -> head<=skid, ONE. Otherwise hold; no input accepted.
- Latency and throughput:
  - Latency in->out is 1 cycle.
  - Sustained 1 beat/cycle while out_ready=1.
  - Beats never dropped, duplicated or reordered, except on flush.
- Bubble:
  - Whenever out_valid=0, out_ctrl=0.
  - out_data holds its last value; downstream must not use it.
- Flush:
  - Highest priority, synchronous. Next state is EMPTY and out_valid=0.
  - Any in_fire in the same cycle is discarded.
  - A beat with out_fire in the same cycle counts as delivered; downstream must qualify it.
  - in_ready returns to 1 the next cycle.
- occupancy: EMPTY=0, ONE=1, FULL=2.
- Reset mid-operation: immediate return to reset values regardless of state; in-flight beats are lost.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- With the macro defined:
  - Port stall_cnt exists.
  - It increments on every cycle with out_valid=1 & out_ready=0 and saturates at 2^CNT_W-1.
  - It is cleared only by rst, not by flush.
- Without the macro: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release, no stimulus -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
- Streaming: in_valid=1 with data 1..8, ctrl=0x00FF, out_ready=1 -> out_data 1..8 on consecutive cycles, first one cycle after the first input, occupancy=1 throughout.
- Backpressure: stream 1..4 with out_ready=0 from cycle 2:
  - head=1, skid=2, occupancy=2, in_ready=0 one cycle later.
  - Beat 3 is held upstream.
  - After out_ready=1, output is 1,2,3,4 with no loss.
- Flush in FULL with in_valid=1 (data 0xA5) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. 0xA5 never appears at the output.
- Async reset asserted mid-cycle while FULL -> outputs zero immediately, without waiting for clk. After release, the stage accepts a new beat 0x55 normally.
- With PIPE_STAGE_STATS_EN, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). A following flush leaves it at 15.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: registered valid/ready handshake with a 2-entry skid buffer, flush and bubble.
// Optional stall statistics counter enabled by defining PIPE_STAGE_STATS_EN.
//
// state    | meaning
// ST_EMPTY | no beat held, in_ready=1
// ST_ONE   | head valid, skid empty, in_ready=1
// ST_FULL  | head and skid valid, in_ready=0
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
`ifdef PIPE_STAGE_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Handshake flags are registered copies of the next state: no comb path to in_ready.
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_data_q;
  assign out_ctrl  = out_valid_q ? head_ctrl_q : '0;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: scoreboard of accepted beats checked against output beats.
// Stall counter scenario runs when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [15:0] in_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [3:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [47:0] sb[$];

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(16), .CNT_W(4)) dut (
`else
  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(16)) dut (
`endif
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Scoreboard monitor: outputs popped first so a beat delivered in a flush cycle still counts.
  initial begin
    logic [47:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (!out_valid) begin
          checks++;
          if (out_ctrl !== 16'h0) begin
            errors++;
            $display("FAIL bubble_ctrl: out_ctrl=%h required 0000", out_ctrl);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got data=%h ctrl=%h, required no beat", out_data, out_ctrl);
          end else begin
            exp = sb.pop_front();
            if ({out_ctrl, out_data} !== exp) begin
              errors++;
              $display("FAIL sb_beat: got ctrl=%h data=%h, required ctrl=%h data=%h",
                       out_ctrl, out_data, exp[47:32], exp[31:0]);
            end
          end
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [31:0] d, input logic [15:0] c);
    logic fired;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    n = 0;
    do begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!fired && n < 50);
    if (!fired) begin
      errors++;
      $display("FAIL send_timeout: beat %h not accepted, required acceptance within 50 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    checks++;
    if ({out_valid, out_ctrl, occupancy, in_ready, out_data} !== {1'b0, 16'h0, 2'd0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset: valid=%b ctrl=%h occ=%0d ready=%b data=%h, required 0 0000 0 1 0",
               out_valid, out_ctrl, occupancy, in_ready, out_data);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(i, 16'h00FF);
      checks++;
      if (out_valid !== 1'b1 || out_data !== i || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b data=%h occ=%0d, required 1 %h 1",
                 i, out_valid, out_data, occupancy, i);
      end
    end
    in_valid = 1'b0;
    idle(1);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd8 || out_ctrl !== 16'h0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL stream_bubble: valid=%b data=%h ctrl=%h occ=%0d, required 0 8 0000 0",
               out_valid, out_data, out_ctrl, occupancy);
    end
    drain_check("stream");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    send(32'd1, 16'h0011);
    out_ready = 1'b0;
    send(32'd2, 16'h0022);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'd1 || dut.skid_data_q !== 32'd2) begin
      errors++;
      $display("FAIL bp_full: occ=%0d ready=%b head=%h skid=%h, required 2 0 1 2",
               occupancy, in_ready, out_data, dut.skid_data_q);
    end
    in_valid = 1'b1;
    in_data  = 32'd3;
    in_ctrl  = 16'h0033;
    idle(3);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'd1) begin
      errors++;
      $display("FAIL bp_hold: occ=%0d ready=%b head=%h, required 2 0 1", occupancy, in_ready, out_data);
    end
    out_ready = 1'b1;
    send(32'd3, 16'h0033);
    send(32'd4, 16'h0044);
    in_valid = 1'b0;
    idle(4);
    drain_check("bp");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h11, 16'h1234);
    send(32'h22, 16'h5678);
    in_valid = 1'b1;
    in_data  = 32'hA5;
    in_ctrl  = 16'hBEEF;
    flush    = 1'b1;
    idle(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 16'h0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL flush: valid=%b ctrl=%h occ=%0d ready=%b, required 0 0000 0 1",
               out_valid, out_ctrl, occupancy, in_ready);
    end
    out_ready = 1'b1;
    idle(4);
    drain_check("flush");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(32'h77, 16'h0F0F);
    send(32'h88, 16'hF0F0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({out_valid, out_data, out_ctrl, occupancy, in_ready} !== {1'b0, 32'h0, 16'h0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h ctrl=%h occ=%0d ready=%b, required 0 0 0000 0 1",
               out_valid, out_data, out_ctrl, occupancy, in_ready);
    end
    idle(2);
    #2;
    rst = 1'b1;
    idle(1);
    out_ready = 1'b1;
    send(32'h55, 16'h0055);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h55 || out_ctrl !== 16'h0055) begin
      errors++;
      $display("FAIL post_reset_beat: valid=%b data=%h ctrl=%h, required 1 55 0055",
               out_valid, out_data, out_ctrl);
    end
    idle(3);
    drain_check("async");
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stall_cnt();
    rst = 1'b0;
    sb.delete();
    idle(1);
    rst = 1'b1;
    idle(1);
    out_ready = 1'b0;
    send(32'h99, 16'h0009);
    in_valid = 1'b0;
    idle(20);
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_sat: stall_cnt=%0d, required 15", stall_cnt);
    end
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(2);
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_after_flush: stall_cnt=%0d, required 15", stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef PIPE_STAGE_STATS_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
